// File: rtl/meas_sequencer.sv
// meas_sequencer: command-driven gated frequency measurement controller with SPI result framing
//
// Clock/reset: reference_clock (rising edge), reset_n (asynchronous, active low).
// Command stream: cmd_valid/cmd_data in, cmd_ready out (1 whenever out of reset).
// Counter control: gate (active gate count), meas_clear (counter clear), capture_enable (count enable).
// Capture: capture_done_async (done flag from the clock-under-test domain), ref_count (reference counter).
// Result stream: res_valid/res_data out, res_ready in; 4-byte frame 0x5A, status, count lo, count hi.
// Status: busy (high outside IDLE).
// Optional feature: define MEAS_TIMEOUT_EN to add the MEASURE timeout (status 0x01, count 0xFFFF).
module meas_sequencer #(
    parameter int CLEAR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        reference_clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic [15:0] gate,
    output logic        meas_clear,
    output logic        capture_enable,
    input  logic        capture_done_async,
    input  logic [15:0] ref_count,
    output logic        res_valid,
    output logic [7:0]  res_data,
    input  logic        res_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CLEAR, MEASURE, SEND} state_t;
    typedef enum logic [1:0] {P_OP, P_LO, P_HI} pstate_t;

    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);

    state_t      state;
    pstate_t     pstate;
    logic [7:0]  gate_lo;
    logic [2:0]  sync;
    logic [7:0]  clr_cnt;
    logic [15:0] start_snap;
    logic [15:0] count;
    logic [7:0]  status;
    logic [1:0]  idx;
    logic        cmd_acc;
    logic        start_cmd;
    logic        abort_cmd;
    logic        done_edge;
`ifdef MEAS_TIMEOUT_EN
    logic [15:0] tcnt;
`endif

    assign cmd_acc   = cmd_valid & cmd_ready;
    assign start_cmd = cmd_acc && pstate == P_OP && cmd_data == 8'hA1;
    assign abort_cmd = cmd_acc && pstate == P_OP && cmd_data == 8'hA2;
    assign done_edge = sync[1] & ~sync[2];

    // Parser runs independently of the FSM; data bytes never reach the opcode decode.
    always_ff @(posedge reference_clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready <= 1'b0;
            pstate    <= P_OP;
            gate_lo   <= 8'h00;
            gate      <= 16'h0000;
        end else begin
            cmd_ready <= 1'b1;
            if (cmd_acc) begin
                case (pstate)
                    P_OP: pstate <= cmd_data == 8'hA0 ? P_LO : P_OP;
                    P_LO: begin
                        gate_lo <= cmd_data;
                        pstate  <= P_HI;
                    end
                    default: begin
                        if (state == IDLE) gate <= {cmd_data, gate_lo};
                        pstate <= P_OP;
                    end
                endcase
            end
        end
    end

    // Two synchroniser flops plus one history flop for rising-edge detection.
    always_ff @(posedge reference_clock or negedge reset_n) begin
        if (!reset_n) sync <= 3'b000;
        else          sync <= {sync[1:0], capture_done_async};
    end

    always_ff @(posedge reference_clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            meas_clear     <= 1'b0;
            capture_enable <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= 8'h00;
            clr_cnt        <= 8'h00;
            start_snap     <= 16'h0000;
            count          <= 16'h0000;
            status         <= 8'h00;
            idx            <= 2'd0;
`ifdef MEAS_TIMEOUT_EN
            tcnt           <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd && gate != 16'h0000) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        meas_clear <= 1'b1;
                        clr_cnt    <= CLR_LAST;
                    end
                end
                CLEAR: begin
                    if (abort_cmd) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        meas_clear <= 1'b0;
                    end else if (clr_cnt == 8'h00) begin
                        state          <= MEASURE;
                        meas_clear     <= 1'b0;
                        capture_enable <= 1'b1;
                        start_snap     <= ref_count;
`ifdef MEAS_TIMEOUT_EN
                        tcnt           <= 16'd1;
`endif
                    end else begin
                        clr_cnt <= clr_cnt - 8'd1;
                    end
                end
                MEASURE: begin
                    // Priority: abort, then done edge, then timeout.
                    if (abort_cmd) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        capture_enable <= 1'b0;
                    end else if (done_edge) begin
                        state          <= SEND;
                        capture_enable <= 1'b0;
                        res_valid      <= 1'b1;
                        res_data       <= 8'h5A;
                        status         <= 8'h00;
                        count          <= ref_count - start_snap;
                        idx            <= 2'd0;
                    end
`ifdef MEAS_TIMEOUT_EN
                    else if (tcnt == 16'(TIMEOUT_CYCLES)) begin
                        state          <= SEND;
                        capture_enable <= 1'b0;
                        res_valid      <= 1'b1;
                        res_data       <= 8'h5A;
                        status         <= 8'h01;
                        count          <= 16'hFFFF;
                        idx            <= 2'd0;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
`endif
                end
                default: begin
                    if (res_valid && res_ready) begin
                        idx      <= idx + 2'd1;
                        res_data <= idx == 2'd0 ? status :
                                    idx == 2'd1 ? count[7:0] :
                                    idx == 2'd2 ? count[15:8] : 8'h00;
                        if (idx == 2'd3) begin
                            state     <= IDLE;
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer: randomized self-checking bench for meas_sequencer against a frame/gate reference model
module tb_meas_sequencer;
    localparam int CLR = 4;
    localparam int TMO = 100;

    logic        reference_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic [15:0] gate;
    logic        meas_clear;
    logic        capture_enable;
    logic        capture_done_async = 1'b0;
    logic [15:0] ref_count = 16'h0000;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_gate = 16'h0000;

    meas_sequencer #(.CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TMO)) dut (
        .reference_clock(reference_clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .gate(gate), .meas_clear(meas_clear), .capture_enable(capture_enable),
        .capture_done_async(capture_done_async), .ref_count(ref_count),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
    );

    always #5 reference_clock = ~reference_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge reference_clock);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic set_gate(input logic [15:0] g, input bit idle);
        send_cmd(8'hA0);
        send_cmd(g[7:0]);
        send_cmd(g[15:8]);
        if (idle) m_gate = g;
        check("gate", gate, m_gate);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int st, input int cnt);
        return i == 0 ? 8'h5A : i == 1 ? 8'(st) : i == 2 ? 8'(cnt % 256) : 8'(cnt / 256);
    endfunction

    task automatic start_and_clear();
        int n;
        send_cmd(8'hA1);
        check("busy_on_start", busy, 1);
        n = 0;
        while (meas_clear && n < 300) begin
            n++;
            tick();
        end
        check("clear_len", n, CLR);
        check("enable_after_clear", capture_enable, 1);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random
    task automatic collect_frame(input int mode, input int st, input int cnt);
        logic [7:0] got [4];
        logic [7:0] held;
        bit stalled;
        int k, cyc;
        k = 0; cyc = 0; stalled = 0; held = 8'h00;
        while (k < 4 && cyc < 200) begin
            res_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            if (stalled) check("stall_stable", res_data, held);
            stalled = 0;
            if (res_valid) begin
                if (res_ready) begin
                    got[k] = res_data;
                    k++;
                end else begin
                    stalled = 1;
                    held = res_data;
                end
            end
            cyc++;
            tick();
        end
        res_ready = 1'b0;
        check("frame_len", k, 4);
        for (int i = 0; i < k; i++) check($sformatf("frame_byte%0d", i), got[i], exp_byte(i, st, cnt));
        check("busy_after_frame", busy, 0);
        check("valid_after_frame", res_valid, 0);
    endtask

    task automatic measure(input logic [15:0] start, input logic [15:0] stop, input int mode, input bit poke);
        int n;
        ref_count = start;
        start_and_clear();
        repeat ($urandom_range(0, 10)) tick();
        if (poke) begin
            set_gate(16'($urandom_range(1, 65535)), 0);
            send_cmd(8'hA1);
        end
        check("enable_held", capture_enable, 1);
        ref_count = stop;
        capture_done_async = 1'b1;
        n = 0;
        while (capture_enable && n < 10) begin
            n++;
            tick();
        end
        check("done_latency_le3", n <= 3, 1);
        check("valid_after_exit", res_valid, 1);
        capture_done_async = 1'b0;
        collect_frame(mode, 0, (int'(stop) - int'(start) + 65536) % 65536);
    endtask

    initial begin
        int n;
        int seen;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_gate", gate, 0);
        check("rst_outs", {busy, meas_clear, capture_enable, res_valid, res_data}, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("cmd_ready_up", cmd_ready, 1);

        send_cmd(8'hA1);
        tick();
        check("start_gate0_ignored", busy, 0);

        send_cmd(8'h55);
        send_cmd(8'h34);
        check("ignored_opcode", gate, m_gate);
        set_gate(16'h1234, 1);
        set_gate(16'hA2A1, 1);
        check("data_not_opcode", busy, 0);
        set_gate(16'h1234, 1);

        measure(16'h0100, 16'h0350, 0, 1);
        measure(16'hFFF0, 16'h0010, 0, 0);
        measure(16'($urandom), 16'($urandom), 1, 0);
        for (int i = 0; i < 4; i++) begin
            set_gate(16'($urandom_range(1, 65535)), 1);
            measure(16'($urandom), 16'($urandom), 2, i[0]);
        end

        ref_count = 16'($urandom);
        start_and_clear();
`ifdef MEAS_TIMEOUT_EN
        n = 1;
        tick();
        while (capture_enable && n < 2000) begin
            n++;
            tick();
        end
        check("timeout_len", n, TMO);
        check("timeout_valid", res_valid, 1);
        collect_frame(0, 1, 65535);
`else
        seen = 0;
        repeat (1000) begin
            if (res_valid) seen++;
            tick();
        end
        check("no_timeout_frame", seen, 0);
        check("still_measuring", capture_enable, 1);
        send_cmd(8'hA2);
        check("abort_busy", busy, 0);
`endif

        send_cmd(8'hA1);
        send_cmd(8'hA2);
        check("abort_clear", {busy, meas_clear}, 0);

        ref_count = 16'h0000;
        start_and_clear();
        repeat (5) tick();
        capture_done_async = 1'b1;
        send_cmd(8'hA2);
        check("abort_measure", {busy, capture_enable}, 0);
        seen = 0;
        repeat (20) begin
            if (res_valid) seen++;
            tick();
        end
        capture_done_async = 1'b0;
        check("abort_no_frame", seen, 0);

        measure(16'h1000, 16'h1001, 0, 0);
        ref_count = 16'h2000;
        start_and_clear();
        ref_count = 16'h3000;
        capture_done_async = 1'b1;
        n = 0;
        while (!res_valid && n < 10) begin
            n++;
            tick();
        end
        check("send_reached", res_valid, 1);
        capture_done_async = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        m_gate = 16'h0000;
        check("async_rst_outs", {cmd_ready, busy, meas_clear, capture_enable, res_valid, res_data}, 0);
        check("async_rst_gate", gate, m_gate);
        tick();
        reset_n = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            if (res_valid || busy) seen++;
            tick();
        end
        res_ready = 1'b0;
        check("no_bytes_after_rst", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/meas_sequencer.md
# meas_sequencer

Measurement controller for the frequency counter, in the `reference_clock` domain.
- Parses gate/start/abort command bytes from the SPI stream source.
- Clears the counters, then drives `capture_enable` for one gated measurement.
- Synchronises the capture-done flag from the clock-under-test domain and computes the reference-clock interval.
- Returns a 4-byte result frame to the SPI stream sink.

## Interface
Parameters:
- `CLEAR_CYCLES`, 4: cycles `meas_clear` is held before enabling (1..255).
- `TIMEOUT_CYCLES`, 65535: MEASURE-state cycle limit (1..65535).

Ports:
- `reference_clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command byte strobe.
- `cmd_data` in 8: command byte.
- `cmd_ready` out 1: always 1 out of reset (commands never stalled).
- `gate` out 16: active gate count, to the comparator.
- `meas_clear` out 1: counter clear request, ORed into counter aclr.
- `capture_enable` out 1: counters' count enable.
- `capture_done_async` in 1: broadened trigger from clock-under-test domain.
- `ref_count` in 16: reference counter output.
- `res_valid` out 1: result byte valid.
- `res_data` out 8: result byte.
- `res_ready` in 1: sink ready.
- `busy` out 1: high in any state except IDLE.

## Operation
- Command parser, independent of main FSM:
  - 0xA0 SET_GATE consumes the next 2 accepted bytes (low, high) as data.
  - 0xA1 START.
  - 0xA2 ABORT.
  - Any other byte in opcode position is ignored.
- SET_GATE updates `gate` only if the FSM is IDLE when the high byte arrives; otherwise it is discarded. Data bytes are never decoded as opcodes.
- FSM states and transitions:
  - IDLE: all drive outputs 0. START with `gate`≠0 → CLEAR. START with `gate`=0 is ignored.
  - CLEAR: `meas_clear`=1 for exactly CLEAR_CYCLES cycles → MEASURE. On entry to MEASURE, `start_snap`←`ref_count`.
  - MEASURE: `capture_enable`=1.
    - Synchronised rising edge of done: `stop_snap`←`ref_count`, status=0x00 → SEND.
    - Timeout counter reaching TIMEOUT_CYCLES: status=0x01, count forced 0xFFFF → SEND.
  - SEND: emits bytes 0x5A, status, count[7:0], count[15:8] under valid/ready → IDLE after the 4th byte is accepted.
- ABORT in CLEAR or MEASURE: → IDLE next cycle, outputs drop, no frame. ABORT in IDLE or SEND is ignored.
- Arithmetic: count = `stop_snap` − `start_snap`, modulo 2^16. Wrap-around is correct by construction.
- Synchroniser: 2 flops plus edge-detect flop on `capture_done_async`. Only a 0→1 transition seen while in MEASURE counts. A level already high on entry is not an edge.
- Done edge and timeout in the same cycle: done wins, status 0x00.
- ABORT and done edge in the same cycle: ABORT wins.
- START while busy: ignored.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 after; all other outputs 0, `gate`=0x0000. Parser returns to opcode position.
- Reset mid-operation: all outputs reach their reset values asynchronously and the frame is abandoned.
- START accepted at cycle N:
  - `busy` and `meas_clear` high from N+1.
  - `meas_clear` low and `capture_enable` high at N+1+CLEAR_CYCLES.
- `capture_done_async` rising before edge T: `capture_enable` low at most 3 cycles after T.
- `res_valid` rises the cycle after MEASURE exits.
- Handshake:
  - A byte transfers on `res_valid`&&`res_ready`.
  - `res_data` is stable while `res_valid`=1 and `res_ready`=0.
  - Back-to-back bytes are allowed when `res_ready` is held high, so the frame takes 4 cycles minimum.
- `busy` deasserts the cycle after the last byte is accepted.
- Timeout fires on the TIMEOUT_CYCLES-th MEASURE cycle.

## Configuration
- `MEAS_TIMEOUT_EN` defined: timeout counter and status 0x01 path present, as above.
- `MEAS_TIMEOUT_EN` undefined: no timeout logic. MEASURE exits only on done edge or ABORT, and status is always 0x00.

## Test plan
- Gate set: bytes A0,34,12 in IDLE → `gate`=0x1234. The same bytes sent during MEASURE leave `gate` unchanged.
- Measurement with CLEAR_CYCLES=4 and `ref_count` driven 0x0100 at enable, then done edge when `ref_count`=0x0350:
  - `meas_clear` high 4 cycles.
  - Frame 5A,00,50,02.
- Wrap-around: start snapshot 0xFFF0, stop 0x0010 → count bytes 20,00.
- Backpressure: `res_ready` toggled 0/1 each cycle → 4 bytes delivered in order with data stable while stalled, `busy` low after the 4th byte.
- Timeout with TIMEOUT_CYCLES=100 and no done edge:
  - Macro defined → `capture_enable` high 100 cycles, frame 5A,01,FF,FF.
  - Macro undefined → no frame after 1000 cycles.
- Abort and reset: ABORT during MEASURE → IDLE with no `res_valid`. `reset_n` low during SEND → all outputs at reset values immediately, and no further bytes after release.
